// File: rtl/cluster_pkg.sv
// Shared types and widths for the cluster spawn path.
package cluster_pkg;
  localparam int ADDR_W          = 8;
  typedef logic [ADDR_W-1:0] addr_t;
  localparam int DEFAULT_N_PROCS = 4;
  localparam int STAT_W          = 16;
  localparam int DROP_CNT_W      = STAT_W;
  localparam int LAUNCH_CNT_W    = STAT_W;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction
endpackage

// File: rtl/spawn_fifo.sv
// Pending-spawn queue: power-of-two depth, wrapping pointers, occupancy held
// in a separate 0..DEPTH counter so full and empty are unambiguous.
module spawn_fifo
  import cluster_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  addr_t                  push_data,
  input  logic                   pop,
  output addr_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  addr_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only entries behind the pointers are read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/spawn_dispatcher.sv
// SPAWN responder: per-core/boot pending slots -> arbiter -> FIFO -> launch on
// the lowest idle core. Define SPAWN_STATS_EN for drop/launch/peak-fill stats.
module spawn_dispatcher
  import cluster_pkg::*;
#(
  parameter int N_PROCS    = DEFAULT_N_PROCS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           proc_clock,
  input  logic                           reset,
  input  logic                           BOOT,
  input  logic [ADDR_W-1:0]              BOOT_ADDR,
  input  logic [N_PROCS-1:0]             TRIGGER_SPAWN,
  input  logic [N_PROCS-1:0][ADDR_W-1:0] SPAWN_ADDR,
  input  logic [N_PROCS-1:0]             RUN,
  output logic [N_PROCS-1:0]             START,
  output logic [N_PROCS-1:0][ADDR_W-1:0] START_ADDR,
  output logic                           ALL_DONE,
  output logic                           DROPPED
`ifdef SPAWN_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0]          DROP_COUNT,
  output logic [$clog2(FIFO_DEPTH):0]    PEAK_FILL,
  output logic [LAUNCH_CNT_W-1:0]        LAUNCH_COUNT
`endif
);
  localparam int NS        = N_PROCS + 1;
  localparam int BOOT_SLOT = N_PROCS;
  localparam int SW        = $clog2(NS);
  localparam int RRW       = $clog2(N_PROCS);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  logic [NS-1:0]      pend_valid;
  addr_t              pend_addr [NS];
  logic [NS-1:0]      trig;
  addr_t              trig_addr [NS];
  logic [NS-1:0]      grant;
  logic [NS-1:0]      occupied;
  logic [RRW-1:0]     rr_ptr;
  logic [RRW-1:0]     rr_next;
  logic [SW-1:0]      rr_idx;
  logic               found;
  logic               hit;
  addr_t              push_data;
  addr_t              fifo_head;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               drop_any;
  logic [N_PROCS-1:0] eligible;
  logic [N_PROCS-1:0] launch_onehot;

  assign trig = {BOOT, TRIGGER_SPAWN};

  always_comb begin
    for (int i = 0; i < N_PROCS; i++) trig_addr[i] = SPAWN_ADDR[i];
    trig_addr[BOOT_SLOT] = BOOT_ADDR;
  end

  // Boot slot wins outright; core slots rotate from the one after the last core granted.
  always_comb begin
    grant     = '0;
    rr_next   = rr_ptr;
    push_data = '0;
    found     = 1'b0;
    hit       = 1'b0;
    rr_idx    = '0;
    if (fifo_full) begin
      grant = '0;
    end else if (pend_valid[BOOT_SLOT]) begin
      grant[BOOT_SLOT] = 1'b1;
      push_data        = pend_addr[BOOT_SLOT];
    end else begin
      for (int k = 0; k < N_PROCS; k++) begin
        rr_idx        = SW'((int'(rr_ptr) + k) % N_PROCS);
        hit           = !found && pend_valid[rr_idx];
        grant[rr_idx] = hit;
        push_data     = hit ? pend_addr[rr_idx] : push_data;
        rr_next       = hit ? RRW'((int'(rr_idx) + 1) % N_PROCS) : rr_next;
        found         = found | hit;
      end
    end
  end

  // A slot being granted this edge counts as free, so it can recapture immediately.
  assign occupied = pend_valid & ~grant;
  assign drop_any = |(trig & occupied);
  assign push     = |grant;

  always_ff @(posedge proc_clock or posedge reset) begin
    if (reset) begin
      pend_valid <= '0;
      for (int i = 0; i < NS; i++) pend_addr[i] <= '0;
      rr_ptr  <= '0;
      DROPPED <= 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (trig[i] && !occupied[i]) begin
          pend_valid[i] <= 1'b1;
          pend_addr[i]  <= trig_addr[i];
        end else if (grant[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
      rr_ptr  <= rr_next;
      DROPPED <= drop_any;
    end
  end

  spawn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (proc_clock),
    .rst       (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A core with START still high has not raised RUN yet, so it is not idle.
  always_comb begin
    eligible = ~RUN & ~START;
    if (fifo_empty) begin
      launch_onehot = '0;
    end else begin
      launch_onehot = eligible & (~eligible + N_PROCS'(1));
    end
  end

  assign pop = |launch_onehot;

  always_ff @(posedge proc_clock or posedge reset) begin
    if (reset) begin
      START      <= '0;
      START_ADDR <= '0;
    end else begin
      START <= launch_onehot;
      for (int j = 0; j < N_PROCS; j++) begin
        if (launch_onehot[j]) START_ADDR[j] <= fifo_head;
      end
    end
  end

  assign ALL_DONE = (RUN == '0) && (pend_valid == '0) && (fifo_count == CW'(0)) && (START == '0);

`ifdef SPAWN_STATS_EN
  always_ff @(posedge proc_clock or posedge reset) begin
    if (reset) begin
      DROP_COUNT   <= '0;
      LAUNCH_COUNT <= '0;
      PEAK_FILL    <= '0;
    end else begin
      if (DROPPED)               DROP_COUNT   <= sat_inc(DROP_COUNT);
      if (START != '0)           LAUNCH_COUNT <= sat_inc(LAUNCH_COUNT);
      if (fifo_count > PEAK_FILL) PEAK_FILL   <= fifo_count;
    end
  end
`endif
endmodule

// File: doc/spawn_dispatcher.md
Name: spawn_dispatcher

Overview:
- Responder end of the SPAWN protocol: collects TRIGGER_SPAWN/SPAWN_ADDR pulses from every Processor in the cluster and queues them.
- Launches each queued address on an idle Processor by driving that core's START/START_ADDR.
- Sits between the Processor array and the cluster top; also performs the initial boot launch.

Parameters:
- N_PROCS, 4, number of Processor instances served (2..16).
- FIFO_DEPTH, 8, pending-spawn queue entries (power of two, >=2).

Ports:
- proc_clock  in  1  cluster processor clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- BOOT  in  1  one-cycle pulse requesting a launch at BOOT_ADDR.
- BOOT_ADDR  in  8  boot entry address.
- TRIGGER_SPAWN  in  N_PROCS  per-core spawn pulse, one cycle wide.
- SPAWN_ADDR  in  N_PROCS x 8  per-core spawn address, valid while its trigger is high.
- RUN  in  N_PROCS  per-core running flag.
- START  out  N_PROCS  per-core launch pulse, registered, one cycle wide.
- START_ADDR  out  N_PROCS x 8  per-core launch address, registered.
- ALL_DONE  out  1  high when no core runs, nothing is pending or queued, and no START is asserted.
- DROPPED  out  1  one-cycle pulse when a request is lost.

Behaviour:
- Reset (async): START=0, START_ADDR=0, DROPPED=0, pending slots cleared, FIFO empty, round-robin pointer=0. ALL_DONE then follows RUN.
- Reset mid-operation: queued and pending requests are discarded, and any START in flight is deasserted immediately.
- Capture stage:
  - N_PROCS+1 one-deep pending slots. Slot i<N_PROCS belongs to core i; slot N_PROCS belongs to BOOT.
  - A trigger on a free slot latches {valid=1, addr}.
  - A trigger on an occupied slot leaves the old entry intact, discards the new one, and pulses DROPPED the next cycle.
- Enqueue stage:
  - Each cycle, if the FIFO is not full, exactly one pending slot is granted and pushed, and that slot is cleared.
  - The BOOT slot has fixed top priority. Core slots are round-robin, starting at the index after the last core granted.
  - FIFO full: slots stay latched; this is backpressure, not a drop.
  - A slot cleared by a grant may capture a new trigger on the same edge.
- Dispatch stage:
  - Core j is eligible when RUN[j]==0 and START[j]==0.
  - START[j] being excluded covers the one-cycle gap before the Processor raises RUN.
  - If the FIFO is non-empty and any core is eligible, the lowest-index eligible core j gets START[j]<=1 and START_ADDR[j]<=head, and the FIFO pops. At most one launch per cycle.
  - START[j] returns to 0 on the next edge. START_ADDR[j] holds its value until the next launch on core j.
- Timing:
  - Minimum latency: trigger high in cycle T -> pending at edge T+1 -> FIFO at edge T+2 -> START high after edge T+3.
  - Simultaneous push and pop on one edge is legal and leaves occupancy unchanged.
  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth; occupancy is held in a separate counter 0..FIFO_DEPTH.
- A core is never STARTed while its RUN=1, since START restarts a Processor.
- ALL_DONE is combinational from registered state and RUN.

Optional Feature:
- Macro SPAWN_STATS_EN.
- When defined, adds outputs DROP_COUNT (16 bits, saturating count of DROPPED pulses), PEAK_FILL (log2(FIFO_DEPTH)+1 bits, maximum occupancy since reset) and LAUNCH_COUNT (16 bits, saturating count of START pulses). All three clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package cluster_pkg holds addr_t (logic [7:0]), the default N_PROCS, and the DROPPED/stat counter widths.
- Sub-module spawn_fifo: synchronous FIFO with push/pop/full/empty/count, depth parameter, addr_t payload.
- The arbiter and dispatcher stay in spawn_dispatcher.

Test Plan:
- Boot: reset, BOOT=1 with BOOT_ADDR=0x10 for one cycle, all RUN=0 -> START[0] high for exactly one cycle, 3 edges later, with START_ADDR[0]=0x10; ALL_DONE=0.
- Simultaneous spawns: cores 1,2,3 trigger together with 0x20/0x30/0x40 while core 0 runs and the others are idle -> three launches on consecutive cycles to cores 1,2,3 carrying 0x20, 0x30, 0x40 (round-robin order from pointer 0).
- Backpressure: FIFO_DEPTH=8, all cores RUN=1, 12 spaced triggers -> FIFO holds 8, pending slots hold the rest, DROPPED stays 0; on release of RUN all 12 dispatch in grant order.
- Drop: core 2 triggers 0x50 and then 0x60 while its slot is still blocked by a full FIFO -> DROPPED pulses once and only 0x50 is ever launched.
- No double launch: a single idle core with two queued entries -> second START is withheld until RUN for that core rises and falls again.
- Reset mid-dispatch: assert reset in the cycle START[1]=1 -> START clears immediately and the queue is empty; after release ALL_DONE=1 with all RUN=0; under SPAWN_STATS_EN, DROP_COUNT=0.
